rf_port_arbiter: RTL and testbench
==================================

Name: rf_port_arbiter

Overview:
- Shares the single-write/dual-read 16x32 register file among NREQ requesters.
- Round-robin arbitration with one command per cycle: either a read of port 1 or a write.
- Also sequences a whole-file clear.
- Sits between the requesters (fetch/load units) and the register file. The arbiter is the only driver of every register-file control input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width.
- AW, 4, register address width (16 entries).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester command request
- we  in  NREQ  per-requester 1=write, 0=read
- addr  in  NREQ*AW  flattened register addresses; requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, combinational
- rvalid  out  NREQ  one-hot read-response strobe
- rdata  out  DW  read data, shared by all requesters, qualified by rvalid
- clr_req  in  1  request to clear all registers
- clr_ack  out  1  one-cycle pulse when the clear has been issued
- rf_en  out  1  register file enable
- rf_rd  out  1  register file read strobe
- rf_wr  out  1  register file write strobe
- rf_rst  out  1  register file clear strobe
- rf_sel_ip  out  AW  write address
- rf_sel_op1  out  AW  read address
- rf_ip  out  DW  write data
- rf_op1  in  DW  register file read port 1

Behaviour:
- Reset values:
  - All outputs 0.
  - ptr=0, state=ARB.
  - Response pipeline empty.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - A transfer happens when req[i]&&gnt[i] is high at a rising edge.
  - At most one gnt bit is high per cycle.
  - gnt is never high while rst, in CLR state, or while clr_req is high.
- Arbitration:
  - Search req starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - After a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
  - Worst-case wait is NREQ-1 grants to other requesters.
- Command stage (registered, one cycle after the transfer edge):
  - rf_en=1.
  - For a write: rf_wr=1, rf_rd=0, rf_sel_ip=addr, rf_ip=wdata.
  - For a read: rf_rd=1, rf_wr=0, rf_sel_op1=addr.
  - With no command: rf_en=rf_rd=rf_wr=0.
  - rf_rd and rf_wr are never both 1.
- Read response:
  - The grant ID is carried through a 2-stage valid/ID pipeline.
  - rvalid[i]=1 and rdata=rf_op1 in the cycle after the register file's read edge, i.e. 2 cycles after the grant cycle.
  - Back-to-back reads stream one response per cycle, in grant order.
  - rdata is 0 whenever no rvalid bit is set.
- Ordering:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later, because commands are serialized.
- FSM (ARB/CLR):
  - ARB: if clr_req=1, issue no grants. Once the response pipeline is empty, go to CLR.
  - CLR (exactly one cycle):
    - rf_en=1, rf_rst=1, rf_rd=rf_wr=0.
    - clr_ack=1.
    - Return to ARB.
  - clr_req held after clr_ack triggers a new clear. Requesters deassert clr_req on clr_ack.
  - clr_req takes priority over any pending req in the same cycle.
- Reset mid-operation:
  - rst during an in-flight read discards the response: no rvalid.
  - The rf_* strobes drop to 0 in the cycle after the rst edge.
  - ptr returns to 0.
- Boundaries:
  - With a single requester continuously requesting, it is granted every cycle.
  - addr=15 and the ptr wrap NREQ-1 -> 0 are both legal.

Decomposition:
- Shared package rf_arb_pkg holds:
  - localparams RF_DEPTH=16, RF_AW=4, RF_DW=32;
  - the state encoding ARB=1'b0, CLR=1'b1.
- One sub-module, rr_arbiter (NREQ parameter):
  - inputs req and ptr; output one-hot gnt;
  - purely combinational rotate/priority-encode.
- The top-level block owns ptr, the FSM, the command registers and the response pipeline.

Test Plan:
- Reset check: after rst, all outputs 0. Requester 0 writes reg 3 = 32'hDEADBEEF, then requester 1 reads reg 3 the next cycle -> rvalid[1] 2 cycles after its grant, rdata = 32'hDEADBEEF.
- Contention: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; no gnt bit is high twice within any 4-cycle window.
- Sparse requests: with ptr=2, req=4'b0011 -> gnt=4'b0001, then ptr=1, then gnt=4'b0010.
- Streaming reads: requester 2 reads regs 0..15 back-to-back after preloading reg k = k*3 -> 16 consecutive rvalid[2] pulses carrying rdata = 0, 3, ..., 45 in order.
- Clear during traffic: clr_req asserted while a read is in flight -> that read's response is delivered, then CLR with rf_rst=1 and clr_ack=1 for exactly one cycle, no grants meanwhile; a later read of reg 5 returns 0.
- Reset mid-operation: rst asserted one cycle after a read grant -> no rvalid, ptr=0, all rf_* strobes 0 in the cycle after the rst edge.

Source files
------------

// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file port arbiter.
// RF_DEPTH/RF_AW/RF_DW describe the 16x32 register file being arbitrated.
package rf_arb_pkg;

    localparam int RF_DEPTH = 16;
    localparam int RF_AW    = 4;
    localparam int RF_DW    = 32;

    typedef enum logic {
        ARB = 1'b0,
        CLR = 1'b1
    } arb_state_t;

    // Round-robin successor of a requester index.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Bundles the requester-side handshake and the register-file control bus.
// master = requesters plus register file; slave = the arbiter.
interface rf_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 4
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               clr_req;
    logic               clr_ack;
    logic               rf_en;
    logic               rf_rd;
    logic               rf_wr;
    logic               rf_rst;
    logic [AW-1:0]      rf_sel_ip;
    logic [AW-1:0]      rf_sel_op1;
    logic [DW-1:0]      rf_ip;
    logic [DW-1:0]      rf_op1;

    modport master (
        output req, we, addr, wdata, clr_req, rf_op1,
        input  gnt, rvalid, rdata, clr_ack,
        input  rf_en, rf_rd, rf_wr, rf_rst, rf_sel_ip, rf_sel_op1, rf_ip
    );

    modport slave (
        input  req, we, addr, wdata, clr_req, rf_op1,
        output gnt, rvalid, rdata, clr_ack,
        output rf_en, rf_rd, rf_wr, rf_rst, rf_sel_ip, rf_sel_op1, rf_ip
    );

endinterface

// File: rtl/rf_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] gnt_dbl;
    logic [NREQ-1:0]   rot_req;
    logic [NREQ-1:0]   rot_gnt;

    assign req_dbl = {req, req} >> ptr;
    assign rot_req = req_dbl[NREQ-1:0];
    assign rot_gnt = rot_req & ~(rot_req - NREQ'(1));
    assign gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    assign gnt     = gnt_dbl[2*NREQ-1:NREQ];

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file command slot per cycle among NREQ requesters and
// sequences whole-file clears; read data returns two cycles after the grant.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    rf_port_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic            grant_en;
    logic [NREQ-1:0] arb_gnt;
    logic [NREQ-1:0] gnt_int;
    logic            grant_any;
    logic            gnt_we;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_wdata;
    logic            pipe_empty;

    logic [PW-1:0][NREQ-1:0] idx_col;
    logic [AW-1:0][NREQ-1:0] addr_col;
    logic [DW-1:0][NREQ-1:0] wdata_col;

    logic            rf_en_reg, rf_rd_reg, rf_wr_reg, rf_rst_reg;
    logic [AW-1:0]   rf_sel_ip_reg, rf_sel_op1_reg;
    logic [DW-1:0]   rf_ip_reg;
    logic            s1_valid_reg, s2_valid_reg;
    logic [PW-1:0]   s1_id_reg, s2_id_reg;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req (bus.req),
        .ptr (ptr_reg),
        .gnt (arb_gnt)
    );

    assign pipe_empty = !s1_valid_reg && !s2_valid_reg;

    // A pending clear blocks new grants so the response pipeline can drain.
    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        case (state_reg)
            ARB: begin
                if (bus.clr_req) begin
                    if (pipe_empty) state_next = CLR;
                end else begin
                    grant_en = 1'b1;
                end
            end
            CLR:     state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    assign gnt_int   = (grant_en && !rst) ? arb_gnt : '0;
    assign grant_any = |gnt_int;
    assign gnt_we    = |(gnt_int & bus.we);
    assign bus.gnt   = gnt_int;

    // One-hot mux of the winner's index, address and data, built bit-column-wise.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
        for (genvar bi = 0; bi < PW; bi++) begin : g_idx
            localparam logic IDX_BIT = 1'((gi >> bi) & 1);
            assign idx_col[bi][gi] = gnt_int[gi] & IDX_BIT;
        end
        for (genvar bi = 0; bi < AW; bi++) begin : g_addr
            assign addr_col[bi][gi] = gnt_int[gi] & bus.addr[gi*AW + bi];
        end
        for (genvar bi = 0; bi < DW; bi++) begin : g_wdata
            assign wdata_col[bi][gi] = gnt_int[gi] & bus.wdata[gi*DW + bi];
        end
    end

    for (genvar gi = 0; gi < PW; gi++) begin : g_idx_or
        assign gnt_idx[gi] = |idx_col[gi];
    end
    for (genvar gi = 0; gi < AW; gi++) begin : g_addr_or
        assign gnt_addr[gi] = |addr_col[gi];
    end
    for (genvar gi = 0; gi < DW; gi++) begin : g_wdata_or
        assign gnt_wdata[gi] = |wdata_col[gi];
    end

    assign ptr_next = grant_any ? PW'(next_index(int'(gnt_idx), NREQ)) : ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_reg      <= 1'b0;
            rf_rd_reg      <= 1'b0;
            rf_wr_reg      <= 1'b0;
            rf_rst_reg     <= 1'b0;
            rf_sel_ip_reg  <= '0;
            rf_sel_op1_reg <= '0;
            rf_ip_reg      <= '0;
            s1_valid_reg   <= 1'b0;
            s1_id_reg      <= '0;
            s2_valid_reg   <= 1'b0;
            s2_id_reg      <= '0;
        end else begin
            rf_en_reg  <= grant_any || (state_next == CLR);
            rf_wr_reg  <= grant_any && gnt_we;
            rf_rd_reg  <= grant_any && !gnt_we;
            rf_rst_reg <= (state_next == CLR);
            if (grant_any && gnt_we) begin
                rf_sel_ip_reg <= gnt_addr;
                rf_ip_reg     <= gnt_wdata;
            end
            if (grant_any && !gnt_we) begin
                rf_sel_op1_reg <= gnt_addr;
            end
            // Stage 1 lines up with the read command, stage 2 with rf_op1.
            s1_valid_reg <= grant_any && !gnt_we;
            s1_id_reg    <= gnt_idx;
            s2_valid_reg <= s1_valid_reg;
            s2_id_reg    <= s1_id_reg;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rvalid
        assign bus.rvalid[gi] = s2_valid_reg && (s2_id_reg == PW'(gi));
    end

    assign bus.rdata      = s2_valid_reg ? bus.rf_op1 : '0;
    assign bus.clr_ack    = (state_reg == CLR);
    assign bus.rf_en      = rf_en_reg;
    assign bus.rf_rd      = rf_rd_reg;
    assign bus.rf_wr      = rf_wr_reg;
    assign bus.rf_rst     = rf_rst_reg;
    assign bus.rf_sel_ip  = rf_sel_ip_reg;
    assign bus.rf_sel_op1 = rf_sel_op1_reg;
    assign bus.rf_ip      = rf_ip_reg;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomised and directed bench for rf_port_arbiter with a transaction-level
// reference model, a register-file stand-in and a read-response scoreboard.
module tb_rf_port_arbiter;
    import rf_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = RF_DW;
    localparam int AW   = RF_AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    rf_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file stand-in: synchronous write, clear and registered read.
    logic [DW-1:0] rf_mem [RF_DEPTH];
    always @(posedge clk) begin
        if (bus.rf_en && bus.rf_rst)
            for (int k = 0; k < RF_DEPTH; k++) rf_mem[k] <= '0;
        if (bus.rf_en && bus.rf_wr) rf_mem[bus.rf_sel_ip] <= bus.rf_ip;
        if (bus.rf_en && bus.rf_rd) bus.rf_op1 <= rf_mem[bus.rf_sel_op1];
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    // Reference model state, in transaction terms.
    int            mptr     = 0;
    bit            m_in_clr = 1'b0;
    bit            rd_prev1 = 1'b0;
    bit            rd_prev2 = 1'b0;
    bit            prev_rst = 1'b0;
    logic [DW-1:0] m_mem [RF_DEPTH];
    bit            e_en = 0, e_rd = 0, e_wr = 0, e_rst = 0;
    logic [AW-1:0] e_sel_ip = '0, e_sel_op1 = '0;
    logic [DW-1:0] e_ip = '0;

    logic [NREQ-1:0] gnt_s     = '0;
    bit              clr_ack_s = 1'b0;
    int              n_clr_ack = 0;
    int              n_rv2 = 0, first_rv2 = -1, last_rv2 = -1;
    logic [DW-1:0]   last_rdata [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s @cycle %0d: bound expired, got no completion, expected completion", name, cyc);
    endtask

    function automatic int pick_idx(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (((r >> j) & NREQ'(1)) != '0) return j;
        end
        return -1;
    endfunction

    // Monitor + model: compare outputs mid-cycle, then advance the model.
    always @(negedge clk) begin
        int            idx;
        logic [NREQ-1:0] exp_gnt;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            nxt_clr;
        bit            rd_now;

        cyc++;
        gnt_s     = bus.gnt;
        clr_ack_s = bus.clr_ack;

        idx = -1;
        if (!rst && !bus.clr_req && !m_in_clr) idx = pick_idx(bus.req, mptr);
        exp_gnt = (idx >= 0) ? (NREQ'(1) << idx) : '0;
        check("gnt", bus.gnt, exp_gnt);
        check("clr_ack", bus.clr_ack, m_in_clr);
        check("rf_en", bus.rf_en, e_en);
        check("rf_rd", bus.rf_rd, e_rd);
        check("rf_wr", bus.rf_wr, e_wr);
        check("rf_rst", bus.rf_rst, e_rst);
        if (e_wr) begin
            check("rf_sel_ip", bus.rf_sel_ip, e_sel_ip);
            check("rf_ip", bus.rf_ip, e_ip);
        end
        if (e_rd) check("rf_sel_op1", bus.rf_sel_op1, e_sel_op1);
        if (prev_rst)
            check("post_rst_outputs", {bus.rf_en, bus.rf_rd, bus.rf_wr, bus.rf_rst, bus.clr_ack, bus.rvalid}, '0);
        if (bus.clr_ack) n_clr_ack++;

        // Read-response scoreboard.
        if (sb_q.size() != 0 && (bus.rvalid != '0 || sb_q[0].due <= cyc)) begin
            rsp_t r;
            r = sb_q.pop_front();
            check("rvalid_id", bus.rvalid, NREQ'(1) << r.id);
            check("rvalid_latency", cyc, r.due);
            check("rdata", bus.rdata, r.data);
            if (bus.rvalid != '0) begin
                last_rdata[r.id] = bus.rdata;
                $display("read rsp: id=%0d data=%08h cycle=%0d", r.id, bus.rdata, cyc);
            end
        end else begin
            check("rvalid_idle", bus.rvalid, '0);
            check("rdata_idle", bus.rdata, '0);
        end
        if (bus.rvalid[2]) begin
            n_rv2++;
            if (first_rv2 < 0) first_rv2 = cyc;
            last_rv2 = cyc;
        end

        // Advance the reference model to the next cycle.
        rd_now = 1'b0;
        if (rst) begin
            mptr = 0;
            sb_q.delete();
            m_in_clr = 1'b0;
            rd_prev1 = 1'b0;
            rd_prev2 = 1'b0;
            {e_en, e_rd, e_wr, e_rst} = '0;
        end else begin
            nxt_clr = !m_in_clr && bus.clr_req && !rd_prev1 && !rd_prev2;
            if (m_in_clr)
                for (int k = 0; k < RF_DEPTH; k++) m_mem[k] = '0;
            {e_en, e_rd, e_wr, e_rst} = '0;
            if (idx >= 0) begin
                w = ((bus.we >> idx) & NREQ'(1)) != '0;
                a = AW'(bus.addr >> (idx * AW));
                d = DW'(bus.wdata >> (idx * DW));
                mptr = (idx + 1) % NREQ;
                e_en = 1'b1;
                if (w) begin
                    e_wr = 1'b1;
                    e_sel_ip = a;
                    e_ip = d;
                    m_mem[a] = d;
                    $display("grant: req=%0d write addr=%0d data=%08h cycle=%0d", idx, a, d, cyc);
                end else begin
                    e_rd = 1'b1;
                    e_sel_op1 = a;
                    rd_now = 1'b1;
                    sb_q.push_back('{id: idx, data: m_mem[a], due: cyc + 2});
                    $display("grant: req=%0d read addr=%0d cycle=%0d", idx, a, cyc);
                end
            end
            if (nxt_clr) begin
                e_en = 1'b1;
                e_rst = 1'b1;
            end
            rd_prev2 = rd_prev1;
            rd_prev1 = rd_now;
            m_in_clr = nxt_clr;
        end
        prev_rst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.req = bus.req & ~gnt_s;
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i] = 1'b1;
        bus.we[i] = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((bus.req != '0 || sb_q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        if (bus.req != '0 || sb_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic do_clear(input int maxc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.clr_req = 1'b1;
        while (!done && n < maxc) begin
            step();
            n++;
            done = clr_ack_s;
        end
        bus.clr_req = 1'b0;
        if (!done) timeout_fail("clear_ack");
    endtask

    task automatic apply_reset();
        bus.req = '0;
        bus.clr_req = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int clr_before;
        for (int k = 0; k < RF_DEPTH; k++) m_mem[k] = '0;
        for (int k = 0; k < NREQ; k++) last_rdata[k] = '0;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.clr_req = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Write then read-after-write through two requesters.
        set_cmd(0, 1'b1, 4'd3, 32'hDEADBEEF);
        step();
        set_cmd(1, 1'b0, 4'd3, '0);
        step();
        drain(20);
        check("raw_reg3", last_rdata[1], 32'hDEADBEEF);

        // Contention from reset: strict 0,1,2,3 rotation.
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 4'd3, '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("contention_order", bus.gnt, NREQ'(1) << (k % NREQ));
            @(posedge clk);
            #1;
        end
        drain(20);

        // Sparse requests with ptr parked at 2.
        apply_reset();
        set_cmd(1, 1'b0, 4'd3, '0);
        step();
        set_cmd(0, 1'b0, 4'd3, '0);
        set_cmd(1, 1'b0, 4'd3, '0);
        @(negedge clk);
        check("sparse_first", bus.gnt, 4'b0001);
        step();
        @(negedge clk);
        check("sparse_second", bus.gnt, 4'b0010);
        drain(20);

        // Preload reg k = 3k, then stream 16 reads from requester 2.
        for (int k = 0; k < RF_DEPTH; k++) begin
            set_cmd(0, 1'b1, AW'(k), DW'(k * 3));
            step();
            check("single_req_granted", bus.req[0], 1'b0);
        end
        n_rv2 = 0;
        first_rv2 = -1;
        for (int k = 0; k < RF_DEPTH; k++) begin
            set_cmd(2, 1'b0, AW'(k), '0);
            step();
            check("stream_granted", bus.req[2], 1'b0);
        end
        drain(20);
        check("stream_count", n_rv2, RF_DEPTH);
        check("stream_back_to_back", last_rv2 - first_rv2, RF_DEPTH - 1);
        check("stream_last_data", last_rdata[2], 32'd45);

        // Clear while a read is in flight, with a competing request pending.
        set_cmd(3, 1'b0, 4'd7, '0);
        step();
        clr_before = n_clr_ack;
        set_cmd(0, 1'b0, 4'd5, '0);
        do_clear(20);
        drain(20);
        check("clear_ack_pulses", n_clr_ack - clr_before, 1);
        check("read_after_clear", last_rdata[0], '0);
        check("inflight_before_clear", last_rdata[3], 32'd21);

        // Reset one cycle after a read grant: response must vanish, ptr -> 0.
        set_cmd(2, 1'b0, 4'd4, '0);
        step();
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 4'd1, '0);
        @(negedge clk);
        check("ptr_after_reset", bus.gnt, 4'b0001);
        drain(20);

        // Random traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            step();
            if (bus.clr_req && clr_ack_s) bus.clr_req = 1'b0;
            else if (!bus.clr_req && $urandom_range(0, 49) == 0) bus.clr_req = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (!bus.req[i] && $urandom_range(0, 99) < 40)
                    set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, RF_DEPTH - 1)), DW'($urandom));
        end
        if (bus.clr_req) do_clear(20);
        drain(40);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
